// File: rtl/lmsm_sequencer_pkg.sv
// Shared ISA constants, instruction field positions and sequencer types.
// The decoder and the LM/SM sequencer both import this package.
package lmsm_sequencer_pkg;

    localparam int NREG = 8;
    localparam int IDXW = $clog2(NREG);

    localparam logic [3:0] OPC_ADD = 4'b0000;
    localparam logic [3:0] OPC_ADI = 4'b0001;
    localparam logic [3:0] OPC_NDU = 4'b0010;
    localparam logic [3:0] OPC_LHI = 4'b0011;
    localparam logic [3:0] OPC_LW  = 4'b0100;
    localparam logic [3:0] OPC_SW  = 4'b0101;
    localparam logic [3:0] OPC_LM  = 4'b0110;
    localparam logic [3:0] OPC_SM  = 4'b0111;
    localparam logic [3:0] OPC_JAL = 4'b1000;
    localparam logic [3:0] OPC_JLR = 4'b1001;
    localparam logic [3:0] OPC_BEQ = 4'b1100;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int RA_MSB   = 11;
    localparam int RA_LSB   = 9;
    localparam int MASK_MSB = 7;
    localparam int MASK_LSB = 0;

    typedef enum logic {IDLE, ISSUE} state_t;

    typedef struct packed {
        logic            vld;
        logic [IDXW-1:0] rd;
        logic [IDXW-1:0] off;
        logic            last;
    } uop_t;

    function automatic logic is_lmsm(input logic [3:0] opc);
        return (opc == OPC_LM) || (opc == OPC_SM);
    endfunction

endpackage

// File: rtl/lmsm_sequencer_if.sv
// ID-stage <-> LM/SM sequencer bus: instruction in, stall and micro-op out.
// master = the sequencer, slave = the pipeline around it.
interface lmsm_sequencer_if;
    import lmsm_sequencer_pkg::*;

    logic [15:0]      inst;
    logic             inst_valid;
    logic             flush;
    logic             uop_ready;
    logic             stall;
    logic             uop_valid;
    logic             uop_is_load;
    logic [IDXW-1:0]  uop_base;
    logic [IDXW-1:0]  uop_reg;
    logic [IDXW-1:0]  uop_offset;
    logic             uop_first;
    logic             uop_last;
    logic [NREG-1:0]  uop_wr_en;

    modport master (
        input  inst, inst_valid, flush, uop_ready,
        output stall, uop_valid, uop_is_load, uop_base, uop_reg, uop_offset,
               uop_first, uop_last, uop_wr_en
    );

    modport slave (
        output inst, inst_valid, flush, uop_ready,
        input  stall, uop_valid, uop_is_load, uop_base, uop_reg, uop_offset,
               uop_first, uop_last, uop_wr_en
    );

endinterface

// File: rtl/lmsm_prio_enc.sv
// Lowest-set-bit encoder: index of the lowest 1, any-bit-set flag, and
// whether exactly one bit is set.
module lmsm_prio_enc #(
    parameter  int W  = 8,
    localparam int IW = $clog2(W)
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          found,
    output logic          single_bit
);

    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--)
            if (vec[i]) idx = IW'(i);
    end

    assign found      = |vec;
    assign single_bit = found & ~|(vec & (vec - 1'b1));

endmodule

// File: rtl/lmsm_sequencer.sv
// Expands LM/SM in the ID stage into one micro-op per set mask bit, in
// ascending register order, while holding PC and IF/ID frozen.
module lmsm_sequencer
    import lmsm_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    lmsm_sequencer_if.master  bus
);

    state_t           state;
    logic [NREG-1:0]  mask_q, mask_nxt;
    logic [IDXW-1:0]  cnt_q, cnt_nxt;
    logic [IDXW-1:0]  base_q, base_nxt;
    logic             ld_q, ld_nxt;
    uop_t             uop_q;

    logic [IDXW-1:0]  enc_idx;
    logic             enc_found, enc_single;
    logic             is_mm, hs;

    assign is_mm = bus.inst_valid & is_lmsm(bus.inst[OPC_MSB:OPC_LSB])
                 & (|bus.inst[MASK_MSB:MASK_LSB]) & ~bus.flush;
    assign hs    = uop_q.vld & bus.uop_ready;

    // Remaining mask after this cycle; the encoder looks ahead at it so
    // the next micro-op fields can be registered.
    always_comb begin
        mask_nxt = mask_q;
        cnt_nxt  = cnt_q;
        base_nxt = base_q;
        ld_nxt   = ld_q;
        if (bus.flush) begin
            mask_nxt = '0;
        end else begin
            case (state)
                IDLE: if (is_mm) begin
                    mask_nxt = bus.inst[MASK_MSB:MASK_LSB];
                    cnt_nxt  = '0;
                    base_nxt = bus.inst[RA_MSB:RA_LSB];
                    ld_nxt   = (bus.inst[OPC_MSB:OPC_LSB] == OPC_LM);
                end
                ISSUE: if (hs) begin
                    mask_nxt = mask_q & (mask_q - 1'b1);
                    if (cnt_q != '1) cnt_nxt = cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    lmsm_prio_enc #(.W(NREG)) u_enc (
        .vec        (mask_nxt),
        .idx        (enc_idx),
        .found      (enc_found),
        .single_bit (enc_single)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mask_q <= '0;
            cnt_q  <= '0;
            base_q <= '0;
            ld_q   <= 1'b0;
            uop_q  <= '0;
        end else begin
            state     <= enc_found ? ISSUE : IDLE;
            mask_q    <= mask_nxt;
            cnt_q     <= cnt_nxt;
            base_q    <= base_nxt;
            ld_q      <= ld_nxt;
            uop_q.vld <= enc_found;
            uop_q.rd  <= enc_found ? enc_idx : '0;
            uop_q.off <= enc_found ? cnt_nxt : '0;
            uop_q.last <= enc_found & enc_single;
        end
    end

    // Stall releases in the cycle of the last handshake so IF/ID can load.
    always_comb begin
        bus.stall = 1'b0;
        if (rst_n && !bus.flush) begin
            case (state)
                IDLE:    bus.stall = is_mm;
                ISSUE:   bus.stall = ~(hs & uop_q.last);
                default: bus.stall = 1'b0;
            endcase
        end
    end

    assign bus.uop_valid   = uop_q.vld;
    assign bus.uop_is_load = ld_q;
    assign bus.uop_base    = base_q;
    assign bus.uop_reg     = uop_q.rd;
    assign bus.uop_offset  = uop_q.off;
    assign bus.uop_first   = uop_q.vld & (cnt_q == '0);
    assign bus.uop_last    = uop_q.last;
    assign bus.uop_wr_en   = (uop_q.vld & ld_q)
                           ? ({{(NREG-1){1'b0}}, 1'b1} << uop_q.rd) : '0;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed vector bench for the LM/SM sequencer: one table row per cycle,
// plus hand-written reset sequences.
module tb_lmsm_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    lmsm_sequencer_if bus();

    lmsm_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [15:0] inst;
        bit          iv, fl, rdy;
        bit          st, vl, ld;
        bit [2:0]    b, rd, off;
        bit          fi, la;
        bit [7:0]    wr;
    } vec_t;

    vec_t tv[$];

    task automatic add(input string nm, input logic [15:0] inst, input bit iv, fl, rdy,
                       input bit st, vl, ld, input bit [2:0] b, rd, off,
                       input bit fi, la, input bit [7:0] wr);
        vec_t v;
        v.nm = nm; v.inst = inst; v.iv = iv; v.fl = fl; v.rdy = rdy;
        v.st = st; v.vl = vl; v.ld = ld; v.b = b; v.rd = rd; v.off = off;
        v.fi = fi; v.la = la; v.wr = wr;
        tv.push_back(v);
    endtask

    // [21]stall [20]valid [19]is_load [18:16]base [15:13]reg [12:10]off [9]first [8]last [7:0]wr_en
    function automatic logic [21:0] act_bundle();
        return {bus.stall, bus.uop_valid, bus.uop_is_load, bus.uop_base, bus.uop_reg,
                bus.uop_offset, bus.uop_first, bus.uop_last, bus.uop_wr_en};
    endfunction

    task automatic chk(input string nm, input logic [21:0] act, input logic [21:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] inst, input bit iv, fl, rdy);
        bus.inst = inst; bus.inst_valid = iv; bus.flush = fl; bus.uop_ready = rdy;
    endtask

    initial begin
        logic [21:0] a, e;
        drive(16'h0000, 0, 0, 0);

        // LM R2, mask 1000_0101
        add("lm85_cap",  16'h6485, 1, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        add("lm85_u0",   16'h6485, 1, 0, 1,  1, 1, 1, 2, 0, 0, 1, 0, 8'h01);
        add("lm85_u1",   16'h6485, 1, 0, 1,  1, 1, 1, 2, 2, 1, 0, 0, 8'h04);
        add("lm85_u2",   16'h6485, 1, 0, 1,  0, 1, 1, 2, 7, 2, 0, 1, 8'h80);
        add("lm85_idle", 16'h0000, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        // SM R1, all eight registers
        add("smff_cap",  16'h72FF, 1, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++)
            add($sformatf("smff_u%0d", i), 16'h72FF, 1, 0, 1, i != 7, 1, 0, 1,
                3'(i), 3'(i), i == 0, i == 7, 8'h00);
        add("smff_idle", 16'h0000, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        // LM R3, mask 0001_0010, EX back-pressures the first micro-op
        add("lm12_cap",  16'h6612, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++)
            add($sformatf("lm12_hold%0d", i), 16'h6612, 1, 0, 0, 1, 1, 1, 3, 1, 0, 1, 0, 8'h02);
        add("lm12_u0",   16'h6612, 1, 0, 1,  1, 1, 1, 3, 1, 0, 1, 0, 8'h02);
        add("lm12_u1",   16'h6612, 1, 0, 1,  0, 1, 1, 3, 4, 1, 0, 1, 8'h10);
        add("lm12_idle", 16'h0000, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        // flush while idle blocks capture
        add("flidle",    16'h6485, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        add("flidle_nx", 16'h0000, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        // empty masks are bubbles
        for (int i = 0; i < 3; i++)
            add($sformatf("lm00_%0d", i), 16'h6400, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        add("sm00",      16'h7000, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        // LM R5, mask F0, flushed on the second micro-op
        add("lmf0_cap",  16'h6AF0, 1, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        add("lmf0_u0",   16'h6AF0, 1, 0, 1,  1, 1, 1, 5, 4, 0, 1, 0, 8'h10);
        add("lmf0_fl",   16'h6AF0, 1, 1, 1,  0, 1, 1, 5, 5, 1, 0, 0, 8'h20);
        add("lmf0_post", 16'h0000, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        add("lmf0_pst2", 16'h0000, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 8'h00);

        // reset state
        repeat (2) @(negedge clk);
        #1 chk("reset_outs", act_bundle(), 22'h0);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i].inst, tv[i].iv, tv[i].fl, tv[i].rdy);
            #1;
            a = act_bundle();
            e = {tv[i].st, tv[i].vl, tv[i].ld, tv[i].b, tv[i].rd, tv[i].off,
                 tv[i].fi, tv[i].la, tv[i].wr};
            if (tv[i].vl) chk(tv[i].nm, a, e);
            else          chk(tv[i].nm, {12'h0, a[21:20], a[7:0]}, {12'h0, e[21:20], e[7:0]});
        end

        // SM R3 mask 0011_1100 interrupted by reset after its first micro-op
        @(negedge clk); drive(16'h763C, 1, 0, 1);
        #1 chk("smrst_cap", {a[21:0] & 22'h0} | {act_bundle() & 22'h300000}, 22'h200000);
        @(negedge clk);
        #1 chk("smrst_u0", act_bundle(), {1'b1, 1'b1, 1'b0, 3'd3, 3'd2, 3'd0, 1'b1, 1'b0, 8'h00});
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk("smrst_async", act_bundle(), 22'h0);
        @(negedge clk);
        #1 chk("smrst_held", act_bundle(), 22'h0);
        rst_n = 1'b1;
        drive(16'h029A, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 a = act_bundle();
            chk($sformatf("add_ign%0d", i), {12'h0, a[21:20], a[7:0]}, 22'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
